// File: rtl/sobol_sng_pkg.sv
// Shared definitions for the Sobol stochastic number generator stage:
// default index width and the direction-vector tables for dims 0 and 1.
package sobol_sng_pkg;

  localparam int CNTWD_DEF = 8;

  // Direction numbers for dim 1. Each m[k] is odd and below 2^(k+1).
  localparam int M1 [8] = '{1, 3, 5, 15, 17, 51, 85, 255};

  // V[dim][k] for a w-bit generator.
  // dim 0 is the plain van der Corput bit-reversal basis.
  function automatic logic [63:0] dir_vec(
    input int dim,
    input int k,
    input int w
  );
    logic [63:0] m;
    m = (dim == 1) ? 64'(M1[k % 8]) : 64'd1;
    return m << (w - 1 - k);
  endfunction

endpackage

// File: rtl/sobol_sng_stage_lsz_detect.sv
// Least-significant-zero priority encoder.
// Ports: cnt (index in), idx (position of lowest zero; CNTWD-1 if all ones).
module lsz_detect #(
  parameter int CNTWD = 8,
  parameter int IW    = (CNTWD > 1) ? $clog2(CNTWD) : 1
) (
  input  logic [CNTWD-1:0] cnt,
  output logic [IW-1:0]    idx
);

  // Scan from the top so the lowest zero wins. An all-ones index
  // falls through to CNTWD-1, which folds the state back to zero
  // on the same edge the upstream counter wraps.
  always_comb begin
    idx = IW'(CNTWD - 1);
    for (int i = CNTWD - 1; i >= 0; i--) begin
      if (!cnt[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/sobol_sng_stage.sv
// Sobol low-discrepancy RNG plus unary bitstream comparator.
// Ports: clk, rst_n (sync, active-low), enable, cnt_in, src -> rng_out, bit_out, bit_vld.
module sobol_sng_stage
  import sobol_sng_pkg::*;
#(
  parameter int CNTWD = CNTWD_DEF,
  parameter int DIM   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNTWD-1:0] cnt_in,
  input  logic [CNTWD-1:0] src,
  output logic [CNTWD-1:0] rng_out,
  output logic             bit_out,
  output logic             bit_vld
);

  localparam int IW = (CNTWD > 1) ? $clog2(CNTWD) : 1;

  logic [CNTWD-1:0] sobol_q;
  logic [IW-1:0]    idx;
  logic [CNTWD-1:0] vsel;

  lsz_detect #(
    .CNTWD (CNTWD),
    .IW    (IW)
  ) u_lsz (
    .cnt (cnt_in),
    .idx (idx)
  );

  // Constant table lookup; folds to a small mux of literals.
  always_comb begin
    vsel = '0;
    for (int k = 0; k < CNTWD; k++) begin
      if (idx == IW'(k)) vsel = CNTWD'(dir_vec(DIM, k, CNTWD));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sobol_q <= '0;
      bit_out <= 1'b0;
      bit_vld <= 1'b0;
    end else begin
      bit_vld <= enable;
      if (enable) begin
        sobol_q <= sobol_q ^ vsel;
        bit_out <= (src > sobol_q);
      end
    end
  end

  assign rng_out = sobol_q;

endmodule

// File: tb/tb_sobol_sng_stage.sv
// Self-checking bench for sobol_sng_stage (CNTWD=4/DIM=0 and CNTWD=8/DIM=1).
// Reference model: Gray-code closed form of the Sobol sequence.
module tb_sobol_sng_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en4, en8;
  logic [3:0] cnt4, src4, rng4;
  logic [7:0] cnt8, src8, rng8;
  logic       bit4, vld4, bit8, vld8;

  int n_run  = 0;
  int n_fail = 0;
  int c4     = 0;
  int c8     = 0;

  sobol_sng_stage #(.CNTWD(4), .DIM(0)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (en4),
    .cnt_in  (cnt4),
    .src     (src4),
    .rng_out (rng4),
    .bit_out (bit4),
    .bit_vld (vld4)
  );

  sobol_sng_stage #(.CNTWD(8), .DIM(1)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (en8),
    .cnt_in  (cnt8),
    .src     (src8),
    .rng_out (rng8),
    .bit_out (bit8),
    .bit_vld (vld8)
  );

  function automatic int v4(input int k);
    return 1 << (3 - k);
  endfunction

  function automatic int v8(input int k);
    int m [8] = '{1, 3, 5, 15, 17, 51, 85, 255};
    return (m[k] << (7 - k)) & 255;
  endfunction

  // Sobol point n = XOR of direction vectors selected by gray(n).
  function automatic int sob4(input int n);
    int g, r;
    g = (n % 16) ^ ((n % 16) >> 1);
    r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r ^= v4(k);
    return r;
  endfunction

  function automatic int sob8(input int n);
    int g, r;
    g = (n % 256) ^ ((n % 256) >> 1);
    r = 0;
    for (int k = 0; k < 8; k++) if (g[k]) r ^= v8(k);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    en4 = 1'b0; en8 = 1'b0;
    cnt4 = '0; cnt8 = '0;
    tick();
    rst_n = 1'b1;
    c4 = 0; c8 = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en4 = 1'b1; en8 = 1'b1;
    cnt4 = 4'd3; cnt8 = 8'd7;
    src4 = 4'hf; src8 = 8'hff;
    tick();
    n_run++;
    if (rng4 !== 4'd0 || vld4 !== 1'b0 || bit4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: rng=%0d vld=%b bit=%b, want 0 0 0", rng4, vld4, bit4);
    end
    n_run++;
    if (rng8 !== 8'd0 || vld8 !== 1'b0 || bit8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: rng=%0d vld=%b bit=%b, want 0 0 0", rng8, vld8, bit8);
    end
    rst_n = 1'b1;
    en4 = 1'b0; en8 = 1'b0;
    c4 = 0; c8 = 0;
  endtask

  task automatic test_sequence4;
    int exp [16] = '{8, 12, 4, 6, 14, 10, 2, 3, 11, 15, 7, 5, 13, 9, 1, 0};
    int prev;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      en4 = 1'b1;
      cnt4 = 4'(c4);
      src4 = 4'($urandom);
      prev = sob4(c4);
      tick();
      n_run++;
      if (rng4 !== 4'(exp[i])) begin
        n_fail++;
        $display("FAIL seq4[%0d]: rng=%0d want %0d", i, rng4, exp[i]);
      end
      n_run++;
      if (vld4 !== 1'b1 || bit4 !== (32'(src4) > prev)) begin
        n_fail++;
        $display("FAIL seq4_bit[%0d]: vld=%b bit=%b want 1 %b", i, vld4, bit4,
                 32'(src4) > prev);
      end
      c4 = (c4 + 1) % 16;
    end
    en4 = 1'b0;
  endtask

  task automatic test_count_ones(input int s);
    int ones;
    do_reset();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      en4 = 1'b1;
      cnt4 = 4'(c4);
      src4 = 4'(s);
      tick();
      if (vld4 && bit4) ones++;
      c4 = (c4 + 1) % 16;
    end
    en4 = 1'b0;
    n_run++;
    if (ones != s) begin
      n_fail++;
      $display("FAIL ones(src=%0d): got %0d want %0d", s, ones, s);
    end
  endtask

  task automatic test_enable_toggle;
    bit pat [5] = '{1, 0, 0, 1, 1};
    int er  [5] = '{8, 8, 8, 12, 4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      en4 = pat[i];
      cnt4 = 4'(c4);
      src4 = 4'($urandom);
      tick();
      n_run++;
      if (rng4 !== 4'(er[i]) || vld4 !== pat[i]) begin
        n_fail++;
        $display("FAIL toggle[%0d]: rng=%0d vld=%b want %0d %b", i, rng4, vld4,
                 er[i], pat[i]);
      end
      if (pat[i]) c4 = (c4 + 1) % 16;
    end
    en4 = 1'b0;
  endtask

  task automatic test_random4;
    bit exp_bit;
    int prev;
    do_reset();
    exp_bit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      en4 = 1'($urandom);
      cnt4 = 4'(c4);
      src4 = 4'($urandom);
      prev = sob4(c4);
      if (en4) begin
        exp_bit = (32'(src4) > prev);
        c4 = (c4 + 1) % 16;
      end
      tick();
      n_run++;
      if (rng4 !== 4'(sob4(c4)) || vld4 !== en4 || bit4 !== exp_bit) begin
        n_fail++;
        $display("FAIL rand4[%0d]: rng=%0d vld=%b bit=%b want %0d %b %b", i,
                 rng4, vld4, bit4, sob4(c4), en4, exp_bit);
      end
    end
    en4 = 1'b0;
  endtask

  task automatic test_midreset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      en4 = 1'b1;
      cnt4 = 4'(c4);
      tick();
      c4++;
    end
    rst_n = 1'b0;
    en4 = 1'b1;
    cnt4 = 4'(c4);
    tick();
    n_run++;
    if (rng4 !== 4'd0 || vld4 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: rng=%0d vld=%b want 0 0", rng4, vld4);
    end
    rst_n = 1'b1;
    c4 = 0;
    cnt4 = 4'd0;
    tick();
    n_run++;
    if (rng4 !== 4'd8 || vld4 !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: rng=%0d vld=%b want 8 1", rng4, vld4);
    end
    en4 = 1'b0;
  endtask

  task automatic test_dim1;
    bit seen [256];
    int distinct, prev, bad;
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      en8 = 1'b1;
      cnt8 = 8'(c8);
      src8 = 8'($urandom);
      prev = sob8(c8);
      tick();
      if (!$isunknown(rng8)) seen[rng8] = 1'b1;
      c8 = (c8 + 1) % 256;
      n_run++;
      if (rng8 !== 8'(sob8(c8)) || bit8 !== (32'(src8) > prev) || vld8 !== 1'b1) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL dim1[%0d]: rng=%0d bit=%b want %0d %b", i, rng8, bit8,
                   sob8(c8), 32'(src8) > prev);
        bad++;
      end
    end
    en8 = 1'b0;
    distinct = 0;
    foreach (seen[i]) if (seen[i]) distinct++;
    n_run++;
    if (distinct != 256) begin
      n_fail++;
      $display("FAIL dim1_perm: distinct=%0d want 256", distinct);
    end
    n_run++;
    if (rng8 !== 8'd0) begin
      n_fail++;
      $display("FAIL dim1_final: rng=%0d want 0", rng8);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en4 = 1'b0; en8 = 1'b0;
    cnt4 = '0; cnt8 = '0;
    src4 = '0; src8 = '0;
    test_reset();
    test_sequence4();
    test_count_ones(8);
    test_count_ones(0);
    test_count_ones(15);
    test_count_ones(int'($urandom_range(1, 14)));
    test_enable_toggle();
    test_random4();
    test_midreset();
    test_dim1();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
